mult_step_sequencer: RTL

MULT_STEP_SEQUENCER -- requirements
Module: mult_step_sequencer

---
 rtl/mult_step_sequencer.sv | 91 +++++++++
 1 files changed

// File: rtl/mult_step_sequencer.sv
// rtl/mult_step_sequencer.sv - control sequencer for an add/shift multiplier
module mult_step_sequencer #(
    parameter  int N_BITS = 8,
    localparam int CW     = $clog2(N_BITS + 1)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Run,
    input  logic          M,
    output logic          clr_ld,
    output logic          add_en,
    output logic          sub_en,
    output logic          shift_en,
    output logic [CW-1:0] step_cnt,
    output logic          last_step,
    output logic          busy,
    output logic          done
);

    localparam logic [CW-1:0] LAST_IDX = CW'(N_BITS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        ADD   = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] step_cnt_q, step_cnt_d;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            step_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            step_cnt_q <= step_cnt_d;
        end
    end

    // step_cnt is cleared on entry to START so the new operation reports step 0
    // from its first cycle; it saturates at N_BITS because SHIFT exits to DONE there.
    always_comb begin
        state_d    = state_q;
        step_cnt_d = step_cnt_q;
        case (state_q)
            IDLE: begin
                if (Run) begin
                    state_d    = START;
                    step_cnt_d = '0;
                end
            end
            START: begin
                state_d    = ADD;
                step_cnt_d = '0;
            end
            ADD: begin
                state_d = SHIFT;
            end
            SHIFT: begin
                step_cnt_d = step_cnt_q + CW'(1);
                if (step_cnt_q < LAST_IDX) begin
                    state_d = ADD;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!Run) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                step_cnt_d = '0;
            end
        endcase
    end

    assign step_cnt  = step_cnt_q;
    assign last_step = (step_cnt_q == LAST_IDX);
    assign clr_ld    = (state_q == START);
    assign add_en    = (state_q == ADD) & M & ~last_step;
    assign sub_en    = (state_q == ADD) & M & last_step;
    assign shift_en  = (state_q == SHIFT);
    assign busy      = (state_q == START) | (state_q == ADD) | (state_q == SHIFT);
    assign done      = (state_q == DONE);

endmodule
